// File: rtl/wdt_pkg.sv
// Package for the watchdog timer.
// Holds the register byte offsets and the FSM state type that the
// timer top module and the testbench both use.
package wdt_pkg;

    localparam logic [15:0] WDEN_ADDR   = 16'h0100;
    localparam logic [15:0] WDLIVE_ADDR = 16'h0200;
    localparam logic [15:0] WTOCNT_ADDR = 16'h0300;
    localparam logic [15:0] COUNT_ADDR  = 16'h0400;
    localparam logic [15:0] STATUS_ADDR = 16'h0500;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } wdt_state_e;

endpackage

// File: rtl/wdt_timer_if.sv
// Peripheral register bus plus watchdog status outputs.
//   wr_en/wr_addr/wr_data : single-cycle register write
//   rd_addr/rd_data       : combinational register read
//   timeout               : watchdog expired (registered level)
//   wdt_busy              : high while counting or expired
// master = bus driver (CPU side), slave = the watchdog.
interface wdt_timer_if;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        timeout;
    logic        wdt_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, timeout, wdt_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, timeout, wdt_busy
    );
endinterface

// File: rtl/wdt_prescaler.sv
// Clock prescaler for the watchdog.
//   clk, rst  : clock, async active-low reset
//   i_run     : advance the prescaler this cycle
//   i_clear   : force the prescaler back to 0 (wins over i_run)
//   o_tick    : one-cycle pulse every PRESCALE running cycles
module wdt_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clear,
    output logic o_tick
);

    // Keep at least one bit so PRESCALE=1 still elaborates; with a
    // single state the compare is always true and every cycle ticks.
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;

    assign o_tick = i_run && !i_clear && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/wdt_timer.sv
// Memory-mapped watchdog timer.
// Firmware programs WTOCNT, sets WDEN and must write WDLIVE bit0=1
// periodically; otherwise timeout asserts and holds until a kick or
// a disable.
//   clk, rst : clock, async active-low reset
//   bus      : register bus + timeout/wdt_busy outputs (slave side)
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    wdt_timer_if.slave  bus
);

    wdt_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [CNT_W-1:0] r_wtocnt;
    logic             r_wden;
    logic             r_timeout, w_timeout_nxt;

    logic w_wr_wden, w_wr_wtocnt, w_kick, w_tick, w_presc_clr;

    assign w_wr_wden   = bus.wr_en && (bus.wr_addr == WDEN_ADDR);
    assign w_wr_wtocnt = bus.wr_en && (bus.wr_addr == WTOCNT_ADDR);
    assign w_kick      = bus.wr_en && (bus.wr_addr == WDLIVE_ADDR) && bus.wr_data[0];

    // Prescaler is held at 0 outside COUNT so that entering COUNT
    // (enable or kick from EXPIRED) always starts a full tick period.
    assign w_presc_clr = (r_state != COUNT) || w_kick;

    wdt_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk     (clk),
        .rst     (rst),
        .i_run   (r_state == COUNT),
        .i_clear (w_presc_clr),
        .o_tick  (w_tick)
    );

    // Config registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wden   <= 1'b0;
            r_wtocnt <= '0;
        end else begin
            if (w_wr_wden)   r_wden   <= bus.wr_data[0];
            if (w_wr_wtocnt) r_wtocnt <= bus.wr_data[CNT_W-1:0];
        end
    end

    // FSM state, counter and timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;
        if (w_wr_wden && !bus.wr_data[0]) begin
            w_state_nxt   = IDLE;
            w_count_nxt   = '0;
            w_timeout_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_wden) begin
                        w_state_nxt = COUNT;
                        w_count_nxt = '0;
                    end else if (w_kick) begin
                        w_count_nxt = '0;
                    end
                end
                COUNT: begin
                    if (w_kick) begin
                        w_count_nxt = '0;
                    end else if (w_tick) begin
                        // Expiry is tested before the increment, so the
                        // counter never passes WTOCNT and cannot wrap.
                        if (r_count >= r_wtocnt) begin
                            w_state_nxt   = EXPIRED;
                            w_timeout_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (w_kick) begin
                        w_state_nxt   = COUNT;
                        w_count_nxt   = '0;
                        w_timeout_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_count_nxt   = '0;
                    w_timeout_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.timeout  = r_timeout;
    assign bus.wdt_busy = (r_state != IDLE);

    // Read mux; reads see register values before any same-cycle write.
    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            WDEN_ADDR:   bus.rd_data = {31'd0, r_wden};
            WTOCNT_ADDR: bus.rd_data = 32'(r_wtocnt);
            COUNT_ADDR:  bus.rd_data = 32'(r_count);
            STATUS_ADDR: bus.rd_data = {30'd0, (r_state != IDLE), r_timeout};
            default:     bus.rd_data = '0;
        endcase
    end

endmodule
